// File: rtl/register_pkg.sv
// Shared constants and helpers for the elastic pipeline register.
package register_pkg;

  localparam int MAX_DEPTH = 16;

  // Bits needed to hold an occupancy of 0..depth, never less than one.
  function automatic int cnt_width(input int depth);
    return ($clog2(depth + 1) < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/register_pipe_if.sv
// Upstream and downstream valid/ready handshake of register_pipe.
interface register_pipe_if #(
  parameter int N = 8
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/register_pipe_stage.sv
// One data/valid pair of the pipe; clear drops the valid bit but keeps the data.
module register_pipe_stage #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         src_valid,
  input  logic [N-1:0] src_data,
  output logic         valid_r,
  output logic [N-1:0] data_r
);

  // Stage state: reset, then clear, then load from the source
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= {N{1'b0}};
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= src_valid;
      if (src_valid) begin
        data_r <= src_data;
      end
    end
  end

endmodule

// File: rtl/register_pipe.sv
// Elastic DEPTH-stage pipeline register with back-pressure and bubble collapsing.
// Optional flush input enabled by defining REGISTER_PIPE_FLUSH_EN.
module register_pipe
  import register_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
`ifdef REGISTER_PIPE_FLUSH_EN
  input  logic                        flush,
`endif
  register_pipe_if.slave              bus,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int CW = cnt_width(DEPTH);

  logic             flush_s;
  logic             advance_s;
  logic [DEPTH:0]   rdy_s;
  logic [DEPTH-1:0] valid_r;
  logic [N-1:0]     data_r [DEPTH];

`ifdef REGISTER_PIPE_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  assign advance_s = enable && !flush_s;

  // Ready chain from the output side back: an empty stage always accepts
  always_comb begin
    rdy_s        = {(DEPTH + 1){1'b0}};
    rdy_s[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy_s[i] = !valid_r[i] || rdy_s[i + 1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic         src_valid_s;
    logic [N-1:0] src_data_s;

    if (i == 0) begin : g_head
      assign src_valid_s = bus.in_valid;
      assign src_data_s  = bus.in_data;
    end else begin : g_body
      assign src_valid_s = valid_r[i - 1];
      assign src_data_s  = data_r[i - 1];
    end

    register_pipe_stage #(.N(N)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush_s),
      .load      (advance_s && rdy_s[i]),
      .src_valid (src_valid_s),
      .src_data  (src_data_s),
      .valid_r   (valid_r[i]),
      .data_r    (data_r[i])
    );
  end

  // Occupancy is the popcount of the registered valid bits
  always_comb begin
    count = {CW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(valid_r[i]);
    end
  end

  assign bus.in_ready  = advance_s && rdy_s[0];
  assign bus.out_valid = advance_s && valid_r[DEPTH - 1];
  assign bus.out_data  = data_r[DEPTH - 1];

endmodule

// File: tb/tb_register_pipe.sv
// Directed bench for register_pipe (DEPTH=3, N=8) with a position-based queue model.
module tb_register_pipe;

  localparam int DEPTH = 3;
  localparam int CW    = register_pkg::cnt_width(DEPTH);

  logic          clk;
  logic          reset;
  logic          enable;
  logic          flush;
  logic [CW-1:0] count;

  register_pipe_if #(.N(8)) bus ();

  register_pipe #(.N(8), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
`ifdef REGISTER_PIPE_FLUSH_EN
    .flush  (flush),
`endif
    .bus    (bus),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit live  = 1'b0;

  // model: each stored word with its stage position, front = oldest
  int         mpos[$];
  logic [7:0] mdat[$];

  logic [7:0] out_q[$];
  int         out_t[$];
  logic [7:0] acc_q[$];
  int         acc_t[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_seq(input string nm, input logic [7:0] got[$], input logic [7:0] exp[$]);
    chk({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk(nm, {24'd0, got[i]}, {24'd0, exp[i]});
    end
  endtask

  function automatic logic exp_in_ready();
    return enable && !flush && !(mpos.size() == DEPTH && !bus.out_ready);
  endfunction

  function automatic logic exp_out_valid();
    return enable && !flush && mpos.size() > 0 && mpos[0] == DEPTH - 1;
  endfunction

  // model update on each rising edge
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      mpos.delete();
      mdat.delete();
      live = 1'b1;
    end else if (flush) begin
      mpos.delete();
      mdat.delete();
    end else if (enable) begin
      logic in_fire;
      logic out_fire;
      int   lim;
      in_fire  = bus.in_valid && exp_in_ready();
      out_fire = exp_out_valid() && bus.out_ready;
      if (out_fire) begin
        void'(mpos.pop_front());
        void'(mdat.pop_front());
      end
      lim = DEPTH - 1;
      for (int k = 0; k < mpos.size(); k++) begin
        mpos[k] = (mpos[k] + 1 < lim) ? mpos[k] + 1 : lim;
        lim     = mpos[k] - 1;
      end
      if (in_fire) begin
        mpos.push_back(0);
        mdat.push_back(bus.in_data);
      end
    end
  end

  // compare DUT against the model and log transfers, away from the active edge
  initial forever begin
    @(negedge clk);
    if (live) begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_in_ready()});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_out_valid()});
      chk("count", 32'(count), 32'(mpos.size()));
      if (exp_out_valid()) begin
        chk("out_data", {24'd0, bus.out_data}, {24'd0, mdat[0]});
      end
      if (!reset && bus.out_valid && bus.out_ready) begin
        out_q.push_back(bus.out_data);
        out_t.push_back(cyc);
      end
      if (!reset && bus.in_valid && bus.in_ready) begin
        acc_q.push_back(bus.in_data);
        acc_t.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_logs();
    out_q.delete();
    out_t.delete();
    acc_q.delete();
    acc_t.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    enable        = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hAA;
    bus.out_ready = 1'b0;
    step();
    step();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'h0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    idle(2);
    chk("rst_nothing_captured", 32'(count), 32'd0);
    clear_logs();

    // streaming
    bus.out_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(v);
      step();
    end
    idle(6);
    exp_q = {8'd1, 8'd2, 8'd3, 8'd4};
    chk_seq("stream_out", out_q, exp_q);
    if (out_t.size() == 4 && acc_t.size() == 4) begin
      chk("stream_latency", 32'(out_t[0] - acc_t[0]), 32'd3);
      chk("stream_back_to_back", 32'(out_t[3] - out_t[0]), 32'd3);
    end else begin
      chk("stream_samples", 32'(out_t.size()), 32'd4);
    end
    clear_logs();

    // back-pressure
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h10 + i);
      step();
    end
    chk("bp_accepted", 32'(acc_q.size()), 32'd3);
    chk("bp_count", 32'(count), 32'd3);
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    bus.in_data   = 8'h20;
    #1;
    chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("bp_full_flow_count", 32'(count), 32'd3);
    idle(6);
    exp_q = {8'h10, 8'h11, 8'h12, 8'h20};
    chk_seq("bp_out", out_q, exp_q);
    clear_logs();

    // bubble collapse
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h55;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bubble_count", 32'(count), 32'd1);
    end
    chk("bubble_at_output", {31'd0, bus.out_valid}, 32'd1);
    chk("bubble_data", {24'd0, bus.out_data}, 32'h55);
    bus.out_ready = 1'b1;
    idle(3);
    exp_q = {8'h55};
    chk_seq("bubble_out", out_q, exp_q);
    clear_logs();

    // enable freeze
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h61;
    step();
    bus.in_data = 8'h62;
    step();
    bus.in_data = 8'h70;
    enable      = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("freeze_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("freeze_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("freeze_count", 32'(count), 32'd2);
      step();
    end
    enable       = 1'b1;
    bus.in_valid = 1'b0;
    idle(5);
    exp_q = {8'h61, 8'h62};
    chk_seq("freeze_out", out_q, exp_q);
    chk_seq("freeze_acc", acc_q, exp_q);
    clear_logs();

`ifdef REGISTER_PIPE_FLUSH_EN
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h81;
    step();
    bus.in_data = 8'h82;
    step();
    chk("flush_pre_count", 32'(count), 32'd2);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    #1;
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    idle(3);
    chk("flush_no_output", 32'(out_q.size()), 32'd0);
    clear_logs();
`endif

    // reset mid-operation
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h91;
    step();
    bus.in_data = 8'h92;
    step();
    reset       = 1'b1;
    bus.in_data = 8'h99;
    step();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    idle(4);
    chk("midrst_no_output", 32'(out_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
